lookup_walker: RTL
==================

LOOKUP_WALKER -- requirements
Module: lookup_walker

Interface
REQ-001 Parameter: WORD_SIZE, default 16, width of one name chunk and of lookup_cont_out.
REQ-002 Parameter: POINTER_SIZE, default 16, width of level node pointers.
REQ-003 Parameter: MAX_LEVELS, default 8, number of FIB levels walked; DW = $clog2(MAX_LEVELS+1).
REQ-004 Parameter: LEVEL_LAT, default 1, cycles from level_req_out to valid level results.
REQ-005 Port: clk, input, 1, the only clock; all state is updated on its rising edge.
REQ-006 Port: rst_n, input, 1, asynchronous, active-low reset.
REQ-007 Ports: chunk_valid_in, input, 1; chunk_in, input, WORD_SIZE; chunk_last_in, input, 1; chunk_ready_out, output, 1; together these form the name chunk stream.
REQ-008 Ports: level_sel_out, output, DW; address_out, output, POINTER_SIZE; lookup_cont_out, output, WORD_SIZE; level_req_out, output, 1; together these form the request to the level array.
REQ-009 Ports: next_pointer_in, input, POINTER_SIZE; is_match_in, input, 1; no_child_in, input, 1; these are the results from the selected level.
REQ-010 Ports: result_valid_out, output, 1; result_ready_in, input, 1; match_found_out, output, 1; match_depth_out, output, DW; match_pointer_out, output, POINTER_SIZE.

Function
REQ-011 The FSM SHALL have the states IDLE, ISSUE, WAIT, EVAL, DRAIN and DONE.
REQ-012 A chunk SHALL transfer on a cycle where chunk_valid_in and chunk_ready_out are both high.
REQ-013 chunk_ready_out SHALL be high only in IDLE and DRAIN.
REQ-014 In IDLE, a chunk transfer SHALL latch the chunk and its last flag, set depth=0 and address=0, clear the match record, and go to ISSUE.
REQ-015 In ISSUE, level_req_out SHALL be high for exactly 1 cycle, with level_sel_out=depth, address_out=current pointer and lookup_cont_out=latched chunk; then the FSM goes to WAIT.
REQ-016 WAIT SHALL count LEVEL_LAT-1 cycles and then go to EVAL; it is skipped when LEVEL_LAT=1.
REQ-017 EVAL SHALL sample the level results.
  - If is_match_in: match_found=1, match_depth=depth+1, match_pointer=next_pointer_in.
  - The longest match wins because deeper levels overwrite shallower ones.
REQ-018 EVAL termination and continuation:
  - Terminate when no_child_in=1, the latched last flag=1, or depth=MAX_LEVELS-1.
  - If terminating with last=1, go to DONE.
  - If terminating with last=0, go to DRAIN.
  - Otherwise, set pointer=next_pointer_in and depth+=1, and go to IDLE-continue (ready high), then ISSUE on the next chunk.
REQ-019 DRAIN SHALL discard chunks without issuing lookups until a chunk with chunk_last_in=1 transfers, then go to DONE.
REQ-020 DONE SHALL hold result_valid_out high with stable result outputs until result_ready_in=1, then return to IDLE with depth cleared.
REQ-021 A new name SHALL NOT be accepted while in DONE, even if result_ready_in and chunk_valid_in are high in the same cycle.
REQ-022 When no match occurs, the result SHALL be match_found_out=0, match_depth_out=0 and match_pointer_out=0.
REQ-023 Chunk-to-result latency for a 1-chunk name with LEVEL_LAT=1 SHALL be 3 cycles.

Reset
REQ-024 Asserting rst_n low SHALL, immediately and at any point mid-walk, force the following:
  - state=IDLE
  - every output 0
  - chunk_ready_out=0 while reset is asserted, then 1 in IDLE
  - pointer, depth and match record cleared

Configuration
REQ-025 LOOKUP_WALKER_STATS_EN defined: the block SHALL add outputs stat_lookups_out[31:0] (count of completed results) and stat_matches_out[31:0] (count of results with match_found=1).
  - Both counters increment on the result handshake, saturate at all-ones, and reset to 0.
REQ-026 LOOKUP_WALKER_STATS_EN undefined: these ports and counters SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-027 The package fib_pkg SHALL hold the walker_state_t enum and the WORD_SIZE/POINTER_SIZE defaults, shared with level.
REQ-028 The latency counter SHALL be inline; there is no sub-module.

Verification
REQ-029 Single chunk "{}", level0 returns is_match=1, next_pointer=0x0001, no_child=1 -> result after 3 cycles: found=1, depth=1, pointer=0x0001.
REQ-030 Chunks "{}","!!"(last):
  - Level0 returns ptr=0x0001 with no match.
  - Level1 receives address_out=0x0001 and cont "!!", and returns match with ptr=0x0007.
  - Required result: depth=2, pointer=0x0007.
REQ-031 Chunks "\\l","ab","cd"(last), level0 no_child=1 no match -> "ab" and "cd" are drained with no level_req_out, and the result is found=0, depth=0.
REQ-032 Hold result_ready_in=0 for 5 cycles in DONE -> outputs stable and chunk_ready_out=0 throughout; the result is consumed on the first cycle ready is high.
REQ-033 Assert rst_n low during WAIT with LEVEL_LAT=3 -> all outputs 0 immediately; after release, a fresh 1-chunk name completes normally.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared FIB lookup definitions: default word/pointer widths, the walker
// state encoding, and a saturating counter helper.
// Used by lookup_walker and by the level array.
package fib_pkg;

    localparam int unsigned WORD_SIZE_DEF    = 16;
    localparam int unsigned POINTER_SIZE_DEF = 16;
    localparam int unsigned STAT_W           = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        EVAL  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } walker_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/lookup_walker.sv
// lookup_walker: walks a multi-level FIB one name chunk per level and reports
// the longest prefix match.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   chunk_valid_in/chunk_in/
//   chunk_last_in/chunk_ready_out    name chunk stream (one chunk per level)
//   level_req_out/level_sel_out/
//   address_out/lookup_cont_out      one-cycle request to the level array
//   next_pointer_in/is_match_in/
//   no_child_in                      level results, valid LEVEL_LAT cycles
//                                    after the request
//   result_valid_out/result_ready_in/
//   match_found_out/match_depth_out/
//   match_pointer_out                result handshake and payload
//   stat_lookups_out/stat_matches_out  saturating result counters, present
//                                    only when LOOKUP_WALKER_STATS_EN is defined
module lookup_walker
    import fib_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = WORD_SIZE_DEF,
    parameter int unsigned POINTER_SIZE = POINTER_SIZE_DEF,
    parameter int unsigned MAX_LEVELS   = 8,
    parameter int unsigned LEVEL_LAT    = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
`ifdef LOOKUP_WALKER_STATS_EN
    output logic [STAT_W-1:0]                   stat_lookups_out,
    output logic [STAT_W-1:0]                   stat_matches_out,
`endif
    input  logic                                chunk_valid_in,
    input  logic [WORD_SIZE-1:0]                chunk_in,
    input  logic                                chunk_last_in,
    output logic                                chunk_ready_out,
    output logic [$clog2(MAX_LEVELS+1)-1:0]     level_sel_out,
    output logic [POINTER_SIZE-1:0]             address_out,
    output logic [WORD_SIZE-1:0]                lookup_cont_out,
    output logic                                level_req_out,
    input  logic [POINTER_SIZE-1:0]             next_pointer_in,
    input  logic                                is_match_in,
    input  logic                                no_child_in,
    output logic                                result_valid_out,
    input  logic                                result_ready_in,
    output logic                                match_found_out,
    output logic [$clog2(MAX_LEVELS+1)-1:0]     match_depth_out,
    output logic [POINTER_SIZE-1:0]             match_pointer_out
);

    localparam int unsigned DW        = $clog2(MAX_LEVELS + 1);
    // WAIT counts 0 .. LEVEL_LAT-2; the counter is kept at least one bit wide.
    localparam int unsigned LW        = (LEVEL_LAT > 2) ? $clog2(LEVEL_LAT - 1) : 1;
    localparam int unsigned WAIT_LAST = (LEVEL_LAT > 1) ? LEVEL_LAT - 2 : 0;

    walker_state_t           state_q, state_d;
    logic [WORD_SIZE-1:0]    chunk_q, chunk_d;
    logic                    last_q, last_d;
    logic                    cont_q, cont_d;      // mid-name: keep depth/pointer/match on next chunk
    logic [DW-1:0]           depth_q, depth_d;
    logic [POINTER_SIZE-1:0] ptr_q, ptr_d;
    logic [LW-1:0]           cnt_q, cnt_d;
    logic                    found_q, found_d;
    logic [DW-1:0]           mdepth_q, mdepth_d;
    logic [POINTER_SIZE-1:0] mptr_q, mptr_d;
    logic                    ready_q, ready_d;
    logic                    req_q, req_d;
    logic                    valid_q, valid_d;

    logic                    chunk_fire;
    logic                    terminate;

    assign chunk_fire = chunk_valid_in && ready_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            chunk_q  <= '0;
            last_q   <= 1'b0;
            cont_q   <= 1'b0;
            depth_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            found_q  <= 1'b0;
            mdepth_q <= '0;
            mptr_q   <= '0;
            ready_q  <= 1'b0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            chunk_q  <= chunk_d;
            last_q   <= last_d;
            cont_q   <= cont_d;
            depth_q  <= depth_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            found_q  <= found_d;
            mdepth_q <= mdepth_d;
            mptr_q   <= mptr_d;
            ready_q  <= ready_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state, datapath updates and registered output strobes.
    always_comb begin
        state_d   = state_q;
        chunk_d   = chunk_q;
        last_d    = last_q;
        cont_d    = cont_q;
        depth_d   = depth_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        found_d   = found_q;
        mdepth_d  = mdepth_q;
        mptr_d    = mptr_q;
        terminate = no_child_in || last_q || (depth_q == DW'(MAX_LEVELS - 1));

        unique case (state_q)
            IDLE: begin
                if (chunk_fire) begin
                    chunk_d = chunk_in;
                    last_d  = chunk_last_in;
                    if (!cont_q) begin
                        depth_d  = '0;
                        ptr_d    = '0;
                        found_d  = 1'b0;
                        mdepth_d = '0;
                        mptr_d   = '0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = (LEVEL_LAT > 1) ? WAIT : EVAL;
            end
            WAIT: begin
                if (cnt_q == LW'(WAIT_LAST)) begin
                    state_d = EVAL;
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            EVAL: begin
                // Deeper levels overwrite shallower ones: longest match wins.
                if (is_match_in) begin
                    found_d  = 1'b1;
                    mdepth_d = depth_q + DW'(1);
                    mptr_d   = next_pointer_in;
                end
                if (terminate) begin
                    cont_d  = 1'b0;
                    state_d = last_q ? DONE : DRAIN;
                end else begin
                    cont_d  = 1'b1;
                    ptr_d   = next_pointer_in;
                    depth_d = depth_q + DW'(1);
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (chunk_fire && chunk_last_in) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready_in) begin
                    depth_d = '0;
                    ptr_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are registered from the next state so they align with it.
        ready_d = (state_d == IDLE) || (state_d == DRAIN);
        req_d   = (state_d == ISSUE);
        valid_d = (state_d == DONE);
    end

    assign chunk_ready_out   = ready_q;
    assign level_req_out     = req_q;
    assign level_sel_out     = depth_q;
    assign address_out       = ptr_q;
    assign lookup_cont_out   = chunk_q;
    assign result_valid_out  = valid_q;
    assign match_found_out   = found_q;
    assign match_depth_out   = mdepth_q;
    assign match_pointer_out = mptr_q;

`ifdef LOOKUP_WALKER_STATS_EN
    logic [STAT_W-1:0] lookups_q;
    logic [STAT_W-1:0] matches_q;

    // Result counters, bumped on the result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookups_q <= '0;
            matches_q <= '0;
        end else if (valid_q && result_ready_in) begin
            lookups_q <= sat_inc(lookups_q);
            if (found_q) begin
                matches_q <= sat_inc(matches_q);
            end
        end
    end

    assign stat_lookups_out = lookups_q;
    assign stat_matches_out = matches_q;
`endif

endmodule
